// File: rtl/pu_ia_icchk.sv
// pu_ia_icchk: 2-way I-cache hit resolve plus miss refill / nc single-word read sequencer, behind the ITLB.
// Latency: hit and stall are combinational in the lookup cycle; a refill is req, ack, 4 beats, 1 tag-write cycle.
// Backpressure: stall holds fetch until back in IDLE; the bus throttles via mem_ack/mem_rvalid. PU_IC_MISS_CNT_EN adds miss_cnt.
module pu_ia_icchk #(
   parameter int TAG_W  = 20,
   parameter int IDX_W  = 8,
   parameter int WORD_W = 32,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_,
   input  logic              lk_valid,
   input  logic [IDX_W-1:0]  lk_idx,
   input  logic [1:0]        lk_ofs,
   input  logic [TAG_W-1:0]  ptag,
   input  logic              nc,
   input  logic [TAG_W-1:0]  tag0,
   input  logic [TAG_W-1:0]  tag1,
   input  logic              vld0,
   input  logic              vld1,
   input  logic              flush,
   output logic              hit,
   output logic              hit_way,
   output logic              stall,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_len,
   input  logic              mem_ack,
   input  logic              mem_rvalid,
   input  logic [WORD_W-1:0] mem_rdata,
   output logic              rf_we,
   output logic              rf_way,
   output logic [IDX_W-1:0]  rf_idx,
   output logic [1:0]        rf_ofs,
   output logic [WORD_W-1:0] rf_data,
   output logic              tag_we,
   output logic              tag_way,
   output logic [IDX_W-1:0]  tag_idx,
   output logic [TAG_W-1:0]  tag_wdata,
   output logic              nc_valid,
   output logic [WORD_W-1:0] nc_data
`ifdef PU_IC_MISS_CNT_EN
   ,
   output logic [31:0]       miss_cnt
`endif
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_REQ  = 3'd1,
      S_FILL = 3'd2,
      S_TAG  = 3'd3,
      S_NCW  = 3'd4
   } state_t;

   state_t              state;
   logic [TAG_W-1:0]    ptag_q;
   logic [IDX_W-1:0]    idx_q;
   logic                victim_q;
   logic                is_nc_q;
   logic                abort_q;
   logic [1:0]          beat_q;
   logic [2**IDX_W-1:0] lru;

   logic m0, m1, lk_go, miss, nc_go, victim, idle;

   assign idle   = (state == S_IDLE);
   assign m0     = vld0 & (tag0 == ptag);
   assign m1     = vld1 & (tag1 == ptag);
   // flush beats a same-cycle lookup: no hit and no miss
   assign lk_go  = rst_ & idle & lk_valid & ~flush;
   assign hit    = lk_go & ~nc & (m0 | m1);
   assign hit_way = hit & ~m0;
   assign miss   = lk_go & ~nc & ~(m0 | m1);
   assign nc_go  = lk_go & nc;
   assign victim = ~vld0 ? 1'b0 : (~vld1 ? 1'b1 : lru[lk_idx]);

   assign stall  = rst_ & (~idle | miss | nc_go);
   assign mem_req = (state == S_REQ) & ~flush;

   assign rf_we   = (state == S_FILL) & mem_rvalid;
   assign rf_way  = victim_q;
   assign rf_idx  = idx_q;
   assign rf_ofs  = beat_q;
   assign rf_data = rf_we ? mem_rdata : '0;

   assign tag_we    = (state == S_TAG);
   assign tag_way   = victim_q;
   assign tag_idx   = idx_q;
   assign tag_wdata = ptag_q;

   // a flush arriving with the returning word still cancels delivery
   assign nc_valid = (state == S_NCW) & mem_rvalid & ~abort_q & ~flush;
   assign nc_data  = nc_valid ? mem_rdata : '0;

   always_ff @(posedge clk) begin
      if (!rst_) begin
         state    <= S_IDLE;
         ptag_q   <= '0;
         idx_q    <= '0;
         victim_q <= 1'b0;
         is_nc_q  <= 1'b0;
         abort_q  <= 1'b0;
         beat_q   <= 2'd0;
         lru      <= '0;
         mem_addr <= '0;
         mem_len  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (hit)
                  lru[lk_idx] <= ~hit_way;
               if (miss | nc_go) begin
                  ptag_q   <= ptag;
                  idx_q    <= lk_idx;
                  victim_q <= victim;
                  is_nc_q  <= nc;
                  abort_q  <= 1'b0;
                  beat_q   <= 2'd0;
                  mem_len  <= ~nc;
                  mem_addr <= nc ? {ptag, lk_idx, lk_ofs, 2'b00} : {ptag, lk_idx, 4'h0};
                  state    <= S_REQ;
               end
            end
            S_REQ: begin
               if (flush)
                  state <= S_IDLE;
               else if (mem_ack)
                  state <= is_nc_q ? S_NCW : S_FILL;
            end
            S_FILL: begin
               if (flush)
                  abort_q <= 1'b1;
               if (mem_rvalid) begin
                  beat_q <= beat_q + 2'd1;
                  if (beat_q == 2'd3) begin
                     beat_q <= 2'd0;
                     state  <= (abort_q | flush) ? S_IDLE : S_TAG;
                  end
               end
            end
            S_TAG: begin
               lru[idx_q] <= ~victim_q;
               state      <= S_IDLE;
            end
            S_NCW: begin
               if (flush)
                  abort_q <= 1'b1;
               if (mem_rvalid)
                  state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef PU_IC_MISS_CNT_EN
   always_ff @(posedge clk) begin
      if (!rst_)
         miss_cnt <= '0;
      else if (miss && miss_cnt != 32'hFFFF_FFFF)
         miss_cnt <= miss_cnt + 32'd1;
   end
`endif

endmodule
